// File: rtl/nebula.sv
// Shared decode-stage types for the nebula core: immediate format selector
// and a helper that classifies compressed (RVC) formats.
package nebula;

    localparam int unsigned IMM_TYPE_W = 4;

    typedef enum logic [IMM_TYPE_W-1:0] {
        i_type = 4'd0,
        s_type = 4'd1,
        b_type = 4'd2,
        u_type = 4'd3,
        j_type = 4'd4,
        c_ci   = 4'd5,
        c_lui  = 4'd6,
        c_lwsp = 4'd7,
        c_swsp = 4'd8,
        c_ls   = 4'd9,
        c_j    = 4'd10,
        c_b    = 4'd11
    } imm_t;

    function automatic logic is_rvc_imm(imm_t t);
        return t inside {c_ci, c_lui, c_lwsp, c_swsp, c_ls, c_j, c_b};
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction for base and compressed formats.
// Undefined selectors, and compressed selectors with RVC_EN=0, give imm=0/illegal=1.
module imm_decode
    import nebula::*;
#(
    parameter int XLEN   = 32,
    parameter bit RVC_EN = 1'b1
) (
    input  logic [31:0]     instr_i,
    input  imm_t            type_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [31:0] imm32;
    logic        ill;
    logic        unused_instr;

    // Opcode bits [1:0] never contribute to any immediate.
    assign unused_instr = ^instr_i[1:0];

    always_comb begin
        imm32 = '0;
        ill   = 1'b0;
        case (type_i)
            i_type: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            s_type: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            b_type: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                             instr_i[30:25], instr_i[11:8], 1'b0};
            u_type: imm32 = {instr_i[31:12], 12'h000};
            j_type: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                             instr_i[20], instr_i[30:21], 1'b0};
            c_ci:   imm32 = {{26{instr_i[12]}}, instr_i[12], instr_i[6:2]};
            c_lui:  imm32 = {{14{instr_i[12]}}, instr_i[12], instr_i[6:2], 12'h000};
            c_lwsp: imm32 = {24'h0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00};
            c_swsp: imm32 = {24'h0, instr_i[8:7], instr_i[12:9], 2'b00};
            c_ls:   imm32 = {25'h0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00};
            c_j:    imm32 = {{20{instr_i[12]}}, instr_i[12], instr_i[8], instr_i[10:9],
                             instr_i[6], instr_i[7], instr_i[2], instr_i[11],
                             instr_i[5:3], 1'b0};
            c_b:    imm32 = {{23{instr_i[12]}}, instr_i[12], instr_i[6:5], instr_i[2],
                             instr_i[11:10], instr_i[4:3], 1'b0};
            default: ill = 1'b1;
        endcase
        if (!RVC_EN && is_rvc_imm(type_i)) begin
            imm32 = '0;
            ill   = 1'b1;
        end
    end

    // Every 32-bit form above is already correctly extended to bit 31, so the
    // 64-bit result just replicates bit 31 (zero-extended forms have it clear).
    if (XLEN == 64) begin : g_x64
        assign imm_o = {{32{imm32[31]}}, imm32};
    end else begin : g_x32
        assign imm_o = imm32;
    end

    assign illegal_o = ill;

endmodule

// File: rtl/imm_unit.sv
// Pipelined immediate generator: imm_decode followed by an output register
// and a skid register so the unit sustains one result per cycle under backpressure.
module imm_unit
    import nebula::*;
#(
    parameter int XLEN   = 32,
    parameter bit RVC_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instr_i,
    input  imm_t            type_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q,   out_imm_d;
    logic            out_ill_q,   out_ill_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
    logic            skid_ill_q,   skid_ill_d;

    logic accept;
    logic drain;

    imm_decode #(
        .XLEN   (XLEN),
        .RVC_EN (RVC_EN)
    ) u_imm_decode (
        .instr_i   (instr_i),
        .type_i    (type_i),
        .imm_o     (dec_imm),
        .illegal_o (dec_ill)
    );

    // ready depends only on held state, so there is no path from ready_i.
    assign ready_o   = !skid_valid_q && !rst_i;
    assign valid_o   = out_valid_q;
    assign imm_o     = out_imm_q;
    assign illegal_o = out_ill_q;

    assign accept = valid_i && ready_o;
    assign drain  = out_valid_q && ready_i;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_ill_d   = skid_ill_q;

        if (drain) begin
            if (skid_valid_q) begin
                out_imm_d    = skid_imm_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        // accept implies skid is empty, so it never collides with a skid->out move
        if (accept) begin
            if (!out_valid_q || drain) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_ill_d   = dec_ill;
            end else begin
                skid_valid_d = 1'b1;
                skid_imm_d   = dec_imm;
                skid_ill_d   = dec_ill;
            end
        end

        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

endmodule

// File: tb/tb_imm_unit.sv
// Bench for imm_unit: three configurations share one input stream and are
// checked against a queue-based reference model of the handshake and decode.
module tb_imm_unit;
    import nebula::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [31:0] instr;
    imm_t        type_s;
    logic        flush;
    logic        ready_i;

    logic        rdy_a, vld_a, ill_a;
    logic [31:0] imm_a;
    logic        rdy_b, vld_b, ill_b;
    logic [63:0] imm_b;
    logic        rdy_c, vld_c, ill_c;
    logic [31:0] imm_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  t;
    } entry_t;

    entry_t q[$];

    always #5 clk = ~clk;

    imm_unit #(.XLEN(32), .RVC_EN(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy_a),
        .instr_i(instr), .type_i(type_s), .flush_i(flush), .valid_o(vld_a),
        .ready_i(ready_i), .imm_o(imm_a), .illegal_o(ill_a));

    imm_unit #(.XLEN(64), .RVC_EN(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy_b),
        .instr_i(instr), .type_i(type_s), .flush_i(flush), .valid_o(vld_b),
        .ready_i(ready_i), .imm_o(imm_b), .illegal_o(ill_b));

    imm_unit #(.XLEN(32), .RVC_EN(1'b0)) dut_c (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy_c),
        .instr_i(instr), .type_i(type_s), .flush_i(flush), .valid_o(vld_c),
        .ready_i(ready_i), .imm_o(imm_c), .illegal_o(ill_c));

    function automatic longint bits(logic [31:0] ins, int hi, int lo);
        longint v;
        v = longint'({32'h0, ins});
        return (v >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    function automatic longint sx(longint v, int w);
        if (((v >> (w - 1)) & 1) != 0) return v - (longint'(1) << w);
        return v;
    endfunction

    // Returns {illegal, 64-bit sign-correct immediate}.
    function automatic logic [64:0] ref_imm(logic [31:0] ins, logic [3:0] t, bit rvc);
        longint v;
        v = 0;
        if (!rvc && t >= 4'd5 && t <= 4'd11) return {1'b1, 64'h0};
        case (t)
            4'd0:  v = sx(bits(ins, 31, 20), 12);
            4'd1:  v = sx((bits(ins, 31, 25) << 5) + bits(ins, 11, 7), 12);
            4'd2:  v = sx((bits(ins, 31, 31) << 12) + (bits(ins, 7, 7) << 11)
                          + (bits(ins, 30, 25) << 5) + (bits(ins, 11, 8) << 1), 13);
            4'd3:  v = sx(bits(ins, 31, 12) << 12, 32);
            4'd4:  v = sx((bits(ins, 31, 31) << 20) + (bits(ins, 19, 12) << 12)
                          + (bits(ins, 20, 20) << 11) + (bits(ins, 30, 21) << 1), 21);
            4'd5:  v = sx((bits(ins, 12, 12) << 5) + bits(ins, 6, 2), 6);
            4'd6:  v = sx(((bits(ins, 12, 12) << 5) + bits(ins, 6, 2)) << 12, 18);
            4'd7:  v = (bits(ins, 3, 2) << 6) + (bits(ins, 12, 12) << 5) + (bits(ins, 6, 4) << 2);
            4'd8:  v = (bits(ins, 8, 7) << 6) + (bits(ins, 12, 9) << 2);
            4'd9:  v = (bits(ins, 5, 5) << 6) + (bits(ins, 12, 10) << 3) + (bits(ins, 6, 6) << 2);
            4'd10: v = sx((bits(ins, 12, 12) << 11) + (bits(ins, 8, 8) << 10)
                          + (bits(ins, 10, 9) << 8) + (bits(ins, 6, 6) << 7)
                          + (bits(ins, 7, 7) << 6) + (bits(ins, 2, 2) << 5)
                          + (bits(ins, 11, 11) << 4) + (bits(ins, 5, 3) << 1), 12);
            4'd11: v = sx((bits(ins, 12, 12) << 8) + (bits(ins, 6, 5) << 6)
                          + (bits(ins, 2, 2) << 5) + (bits(ins, 11, 10) << 3)
                          + (bits(ins, 4, 3) << 1), 9);
            default: return {1'b1, 64'h0};
        endcase
        return {1'b0, v};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic       exp_rdy;
        logic       exp_vld;
        logic [64:0] r1, r0;
        exp_rdy = !rst && (q.size() < 2);
        exp_vld = (q.size() != 0);
        chk("ready_a", 64'(rdy_a), 64'(exp_rdy));
        chk("ready_b", 64'(rdy_b), 64'(exp_rdy));
        chk("ready_c", 64'(rdy_c), 64'(exp_rdy));
        chk("valid_a", 64'(vld_a), 64'(exp_vld));
        chk("valid_b", 64'(vld_b), 64'(exp_vld));
        chk("valid_c", 64'(vld_c), 64'(exp_vld));
        if (exp_vld) begin
            r1 = ref_imm(q[0].ins, q[0].t, 1'b1);
            r0 = ref_imm(q[0].ins, q[0].t, 1'b0);
            chk("imm_a", 64'(imm_a), {32'h0, r1[31:0]});
            chk("ill_a", 64'(ill_a), 64'(r1[64]));
            chk("imm_b", imm_b, r1[63:0]);
            chk("ill_b", 64'(ill_b), 64'(r1[64]));
            chk("imm_c", 64'(imm_c), {32'h0, r0[31:0]});
            chk("ill_c", 64'(ill_c), 64'(r0[64]));
        end
    endtask

    // Advance the model with the current inputs, clock once, then compare.
    task automatic tick();
        bit acc, drn;
        entry_t e;
        acc = valid_i && !rst && (q.size() < 2);
        drn = (q.size() != 0) && ready_i;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                e.ins = instr;
                e.t   = type_s;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic put(logic [31:0] ins, logic [3:0] t);
        valid_i = 1'b1;
        instr   = ins;
        type_s  = imm_t'(t);
        tick();
        valid_i = 1'b0;
    endtask

    logic [31:0] bp_ins [4];
    logic [3:0]  bp_t   [4];

    initial begin
        rst = 1'b1; valid_i = 1'b0; instr = '0; type_s = i_type;
        flush = 1'b0; ready_i = 1'b1;
        #2;
        tick();
        tick();
        chk("rst_imm_a", 64'(imm_a), 64'h0);
        chk("rst_ill_a", 64'(ill_a), 64'h0);
        chk("rst_imm_b", imm_b, 64'h0);
        rst = 1'b0;
        #1;
        check_all();

        // Directed decode cases from the test plan
        put(32'hFFF00093, 4'd0);
        chk("i_type_const", 64'(imm_a), 64'hFFFFFFFF);
        put(32'h800000EF, 4'd4);
        chk("j_type_const", 64'(imm_a), 64'hFFF00000);
        put(32'h800002B7, 4'd3);
        chk("u_type_x64_const", imm_b, 64'hFFFFFFFF80000000);
        put(32'h0000BFFD, 4'd10);
        chk("c_j_const", 64'(imm_a), 64'hFFFFFFFE);
        chk("c_j_norvc_ill", 64'(ill_c), 64'h1);
        chk("c_j_norvc_imm", 64'(imm_c), 64'h0);
        chk("c_j_norvc_vld", 64'(vld_c), 64'h1);
        put(32'h00004412, 4'd7);
        chk("c_lwsp_const", 64'(imm_a), 64'h4);
        put(32'h12345678, 4'd14);
        chk("undef_ill", 64'(ill_a), 64'h1);
        tick();

        // Backpressure: four held inputs, ready_i low for the first three cycles
        bp_ins[0] = 32'hFFF00093; bp_t[0] = 4'd0;
        bp_ins[1] = 32'h00A12423; bp_t[1] = 4'd1;
        bp_ins[2] = 32'hFE000EE3; bp_t[2] = 4'd2;
        bp_ins[3] = 32'h0000D87D; bp_t[3] = 4'd11;
        begin
            int idx = 0;
            for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
                bit acc;
                ready_i = (cyc >= 3);
                valid_i = 1'b1;
                instr   = bp_ins[idx];
                type_s  = imm_t'(bp_t[idx]);
                acc     = !rst && (q.size() < 2);
                tick();
                if (acc) idx++;
                if (cyc == 1) chk("bp_ready_low", 64'(rdy_a), 64'h0);
            end
            chk("bp_all_accepted", 64'(idx), 64'd4);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) tick();

        // Flush with both entries held and a new input offered
        ready_i = 1'b0;
        put(32'h00100093, 4'd0);
        put(32'h00200093, 4'd0);
        chk("pre_flush_full", 64'(rdy_a), 64'h0);
        valid_i = 1'b1; instr = 32'h00300093; flush = 1'b1;
        tick();
        flush = 1'b0; valid_i = 1'b0;
        chk("flush_valid", 64'(vld_a), 64'h0);
        chk("flush_ready", 64'(rdy_a), 64'h1);
        ready_i = 1'b1;
        repeat (2) tick();

        // Reset mid-stream behaves like flush
        ready_i = 1'b0;
        put(32'h00400093, 4'd0);
        put(32'h00500093, 4'd0);
        valid_i = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; valid_i = 1'b0;
        #1;
        check_all();
        chk("rst_mid_valid", 64'(vld_a), 64'h0);
        chk("rst_mid_ready", 64'(rdy_a), 64'h1);
        ready_i = 1'b1;
        repeat (2) tick();

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            valid_i = ($urandom_range(3) != 0);
            ready_i = ($urandom_range(2) != 0);
            flush   = ($urandom_range(39) == 0);
            instr   = $urandom;
            type_s  = imm_t'(4'($urandom_range(15)));
            tick();
        end
        valid_i = 1'b0; flush = 1'b0; ready_i = 1'b1;
        repeat (3) tick();
        chk("final_empty", 64'(vld_a), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_unit.md
# imm_unit

Parametrised, pipelined immediate-generation unit for the nebula decode stage. It takes a raw instruction word and an immediate-format selector, and returns the sign- or zero-extended immediate at XLEN width. It covers the five base RV formats and, optionally, the RVC compressed formats. It sits between instruction fetch/expand and the register-read stage, with a valid/ready handshake on both sides and a two-entry skid buffer, so it sustains one result per cycle under backpressure.

## Interface
Parameters:
- XLEN, 32, immediate/output width; legal values 32 or 64.
- RVC_EN, 1, 1 = compressed formats decoded; 0 = compressed selectors flagged illegal.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  upstream holds a valid instruction.
- ready_o  out  1  unit accepts input this cycle.
- instr_i  in  32  instruction word; compressed instructions occupy [15:0].
- type_i  in  nebula::imm_t  immediate format selector.
- flush_i  in  1  discard all held and incoming entries.
- valid_o  out  1  imm_o/illegal_o are valid.
- ready_i  in  1  downstream accepts the output this cycle.
- imm_o  out  XLEN  generated immediate.
- illegal_o  out  1  selector unsupported; imm_o forced to 0.

## Operation
- Base formats follow the RV spec:
  - I, S and B formats sign-extend from instr[31].
  - U is {instr[31:12], 12'h0}, sign-extended from bit 31 when XLEN=64.
  - J format follows the RV spec.
- Compressed formats (RVC_EN=1):
  - c_ci: sext {[12],[6:2]}.
  - c_lui: sext {[12],[6:2],12'h0}.
  - c_lwsp: zext {[3:2],[12],[6:4],2'b0}.
  - c_swsp: zext {[8:7],[12:9],2'b0}.
  - c_ls: zext {[5],[12:10],[6],2'b0}.
  - c_j: sext {[12],[8],[10:9],[6],[7],[2],[11],[5:3],1'b0}.
  - c_b: sext {[12],[6:5],[2],[11:10],[4:3],1'b0}.
- illegal_o=1 and imm_o=0 in these cases:
  - type_i is not a defined enumerator.
  - type_i is a compressed selector and RVC_EN=0.
- Illegal selectors never stall the pipeline and never cause a simulation fatal.
- Storage is an output register (out_q) plus a skid register (skid_q), each with its own valid bit.
- Input accept: valid_i && ready_o.
  - If out_q is empty, or is being drained this cycle (valid_o && ready_i), the new entry loads into out_q.
  - Otherwise it loads into skid_q.
- On output drain with skid_q valid, skid_q moves to out_q and skid_q empties.
- ready_o = !skid_valid && !rst_i (registered source, no combinational path from ready_i).
- flush_i: both valid bits clear at the next edge; any input accepted that cycle is dropped. Flush has priority over accept and drain.

## Timing
- Latency: 1 cycle from accept to valid_o when the unit is empty.
- Throughput: 1 per cycle while ready_i=1.
- Reset values: valid_o=0, imm_o=0, illegal_o=0, skid empty.
  - ready_o=0 during the reset cycle and 1 on the first cycle after reset.
- Output stability: imm_o/illegal_o hold stable while valid_o && !ready_i.
- Order: entries leave in order; there is no loss or duplication under any valid_i/ready_i pattern.
- Full (both entries valid): ready_o=0.
  - A drain that cycle reopens ready_o on the next cycle, not the same cycle.
- Reset asserted mid-stream: all entries are discarded at that edge, exactly as for flush.

## Structure
- In the nebula package:
  - Extend imm_t to 4 bits with i_type, s_type, b_type, u_type, j_type, c_ci, c_lui, c_lwsp, c_swsp, c_ls, c_j and c_b.
  - Add a function is_rvc_imm(imm_t).
- Sub-module imm_decode: purely combinational, parametrised by XLEN and RVC_EN, producing {imm, illegal}.
- imm_unit wraps imm_decode with the skid/output registers and handshake.

## Test plan
- XLEN=32, i_type, instr 0xFFF00093 -> imm_o 0xFFFFFFFF one cycle after accept.
- j_type, instr 0x800000EF -> imm_o 0xFFF00000.
- XLEN=64, u_type, instr 0x800002B7 -> imm_o 0xFFFFFFFF80000000.
- RVC_EN=1, c_j, instr 0x0000BFFD -> imm_o 0xFFFFFFFE.
- RVC_EN=1, c_lwsp, instr 0x00004412 -> imm_o 0x4.
- RVC_EN=0, c_j -> illegal_o=1, imm_o=0, valid_o=1.
- Backpressure: 4 back-to-back inputs with ready_i=0 for cycles 1–3.
  - ready_o falls after the second accept.
  - Outputs appear in order once ready_i=1; no loss.
  - valid_o never drops between entries.
- flush_i with both entries valid plus valid_i high -> valid_o=0 next cycle, ready_o=1, nothing emitted.
- Reset asserted with both entries valid -> same outcome as flush.
